cache_dfp_arbiter: RTL
======================

// Module: cache_dfp_arbiter
// PURPOSE
//  Shares the single memory-side DFP port between the icache and dcache controllers.
//  Each cache FSM holds its DFP request until it sees its dfp_resp; the arbiter grants one requester at a time,
//  routes address/data to memory, and steers mem_resp/mem_rdata back to the granted side only.
//  Round-robin between caches on contention; a grant is held for the whole transaction (no preemption).
// PARAMETERS
//  ADDR_WIDTH  32   byte address width of DFP requests
//  LINE_WIDTH  256  cache line width in bits (one burst-free line transfer per transaction)
// PORTS
//  clk          in   1           clock; all state updates on posedge clk
//  rst          in   1           reset, asynchronous, active-high
//  i_dfp_read   in   1           icache line read request; held until i_dfp_resp
//  i_dfp_addr   in   ADDR_WIDTH  icache line address
//  i_dfp_rdata  out  LINE_WIDTH  read data to icache; valid when i_dfp_resp
//  i_dfp_resp   out  1           icache transaction complete (1-cycle pulse)
//  d_dfp_read   in   1           dcache line read request; held until d_dfp_resp
//  d_dfp_write  in   1           dcache line writeback request; held until d_dfp_resp
//  d_dfp_addr   in   ADDR_WIDTH  dcache line address
//  d_dfp_wdata  in   LINE_WIDTH  dcache writeback data
//  d_dfp_rdata  out  LINE_WIDTH  read data to dcache; valid when d_dfp_resp
//  d_dfp_resp   out  1           dcache transaction complete (1-cycle pulse)
//  mem_read     out  1           memory read strobe, held until mem_resp
//  mem_write    out  1           memory write strobe, held until mem_resp
//  mem_addr     out  ADDR_WIDTH  memory address (granted requester)
//  mem_wdata    out  LINE_WIDTH  memory write data (dcache wdata)
//  mem_rdata    in   LINE_WIDTH  memory read data; valid with mem_resp
//  mem_resp     in   1           memory transaction complete
//  busy         out  1           high whenever state != IDLE
// BEHAVIOUR
//  - State register: IDLE, GRANT_I, GRANT_D; plus 1-bit last_grant (0=icache, 1=dcache).
//  - Reset (async): state=IDLE, last_grant=1 (icache wins first contention); while rst high and after, until a grant:
//    mem_read=mem_write=0, i/d_dfp_resp=0, busy=0. rdata outputs may be any value when resp=0 (drive mem_rdata).
//  - IDLE: no mem strobes. i_req=i_dfp_read, d_req=d_dfp_read|d_dfp_write.
//    only i_req -> GRANT_I; only d_req -> GRANT_D; both -> grant side != last_grant; none -> stay.
//    Grant decision registered: first mem strobe appears the cycle after the request is first seen in IDLE.
//  - On entering a GRANT state, last_grant updated to that side.
//  - GRANT_I: mem_read=1, mem_write=0, mem_addr=i_dfp_addr. GRANT_D: mem_read=d_dfp_read, mem_write=d_dfp_write,
//    mem_addr=d_dfp_addr, mem_wdata=d_dfp_wdata. Strobes/addr combinational from state + live requester inputs.
//  - mem_resp in GRANT_x: same-cycle (combinational) x_dfp_resp=1, x_dfp_rdata=mem_rdata; next state IDLE.
//    The non-granted side never sees resp. mem_resp in IDLE is ignored (no resp to either side).
//  - Post-transaction IDLE cycle is mandatory: back-to-back transactions have >=1 cycle gap with strobes low,
//    so a requester that immediately re-requests is re-arbitrated against the other side.
//  - Grant held regardless of the other requester; the other side's request waits (its inputs untouched).
//  - Requester dropping its request mid-grant is illegal; d_dfp_read&d_dfp_write both high is illegal;
//    both flagged by simulation-only assertions. RTL behaviour then: strobes follow inputs, grant still held until mem_resp.
//  - rst asserted mid-transaction: strobes drop asynchronously, no resp issued; a later stray mem_resp is ignored.
//  - Fairness: under continuous contention grants strictly alternate I,D,I,D...; max wait = one other transaction + 2 cycles.
// TESTING
//  1. icache only: i_dfp_read=1 addr=0x0000_1000, mem_resp after 5 cycles with rdata=0xA5..A5 -> mem_read from cycle 1,
//     i_dfp_resp 1-cycle pulse with rdata=0xA5..A5, d_dfp_resp stays 0, busy low next cycle.
//  2. dcache writeback: d_dfp_write=1 addr=0x0000_2040 wdata=0x1234.. -> mem_write=1, mem_addr/wdata match, mem_read=0, d_dfp_resp on mem_resp.
//  3. Simultaneous i and d requests after reset -> icache granted first, then dcache after one IDLE cycle; mem_addr switches accordingly.
//  4. Continuous contention for 6 transactions -> grant order I,D,I,D,I,D; each resp only to granted side.
//  5. Assert rst during GRANT_D before mem_resp -> mem_read/mem_write fall in same cycle, no d_dfp_resp; stray mem_resp after reset -> no resp to either.
//  6. mem_resp pulsed while IDLE with no requests -> i_dfp_resp=d_dfp_resp=0, state stays IDLE.

Source files
------------

// File: rtl/cache_dfp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_dfp_arbiter
// Purpose  : Round-robin arbiter sharing one memory DFP port between the
//            icache and dcache; a grant is held for a whole transaction.
// Revision : 1.0 - initial release
// ============================================================================
module cache_dfp_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_dfp_read,
    input  logic [ADDR_WIDTH-1:0] i_dfp_addr,
    output logic [LINE_WIDTH-1:0] i_dfp_rdata,
    output logic                  i_dfp_resp,

    input  logic                  d_dfp_read,
    input  logic                  d_dfp_write,
    input  logic [ADDR_WIDTH-1:0] d_dfp_addr,
    input  logic [LINE_WIDTH-1:0] d_dfp_wdata,
    output logic [LINE_WIDTH-1:0] d_dfp_rdata,
    output logic                  d_dfp_resp,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp,

    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT_I = 2'd1,
        S_GRANT_D = 2'd2
    } state_t;

    localparam logic c_SIDE_I = 1'b0;
    localparam logic c_SIDE_D = 1'b1;

    state_t r_state;
    state_t w_next_state;
    logic   r_last_grant;

    logic   w_i_req;
    logic   w_d_req;

    assign w_i_req = i_dfp_read;
    assign w_d_req = d_dfp_read | d_dfp_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= c_SIDE_D;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && w_next_state == S_GRANT_I) begin
                r_last_grant <= c_SIDE_I;
            end else if (r_state == S_IDLE && w_next_state == S_GRANT_D) begin
                r_last_grant <= c_SIDE_D;
            end
        end
    end

    // Grants always return to IDLE after mem_resp, so every transaction is
    // followed by an arbitration cycle with strobes low.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_i_req && w_d_req) begin
                    w_next_state = (r_last_grant == c_SIDE_D) ? S_GRANT_I : S_GRANT_D;
                end else if (w_i_req) begin
                    w_next_state = S_GRANT_I;
                end else if (w_d_req) begin
                    w_next_state = S_GRANT_D;
                end
            end
            S_GRANT_I, S_GRANT_D: begin
                if (mem_resp) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = i_dfp_addr;
        i_dfp_resp = 1'b0;
        d_dfp_resp = 1'b0;
        unique case (r_state)
            S_GRANT_I: begin
                mem_read   = 1'b1;
                mem_addr   = i_dfp_addr;
                i_dfp_resp = mem_resp;
            end
            S_GRANT_D: begin
                mem_read   = d_dfp_read;
                mem_write  = d_dfp_write;
                mem_addr   = d_dfp_addr;
                d_dfp_resp = mem_resp;
            end
            default: begin
            end
        endcase
    end

    // Return data is only qualified by the per-side resp, so it fans out raw.
    assign mem_wdata   = d_dfp_wdata;
    assign i_dfp_rdata = mem_rdata;
    assign d_dfp_rdata = mem_rdata;
    assign busy        = (r_state != S_IDLE);

`ifndef SYNTHESIS
    a_d_rw_exclusive : assert property (@(posedge clk) disable iff (rst)
        !(d_dfp_read && d_dfp_write))
        else $error("dcache drove read and write together");

    a_i_hold : assert property (@(posedge clk) disable iff (rst)
        (r_state == S_GRANT_I) |-> i_dfp_read)
        else $error("icache dropped its request while granted");

    a_d_hold : assert property (@(posedge clk) disable iff (rst)
        (r_state == S_GRANT_D) |-> (d_dfp_read || d_dfp_write))
        else $error("dcache dropped its request while granted");
`endif

endmodule
`default_nettype wire
